// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the PC/IF/ID/EX/MEM/WB pipeline. It merges stall requests,
// sequences exception, ertn, branch and idle flushes, and drives the single redirect to the PC stage.
module pipeline_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stallreq_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              excp_i,
  input  logic [ADDR_W-1:0] excp_entry_i,
  input  logic              ertn_i,
  input  logic [ADDR_W-1:0] ertn_target_i,
  input  logic              idle_i,
  input  logic [ADDR_W-1:0] idle_pc_i,
  input  logic              int_pending_i,
  output logic [5:0]        stall_o,
  output logic [5:0]        flush_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              busy_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [5:0] FLUSH_ALL   = 6'h3F;
  localparam logic [5:0] FLUSH_FRONT = 6'b000110;
  localparam logic [5:0] FLUSH_ID    = 6'b000100;

  typedef enum logic [1:0] {RUN, FLUSH, IDLE, WAKE} state_t;

  state_t            state_p1, state_nxt;
  logic [CNT_W-1:0]  cnt_p1, cnt_nxt;
  logic [5:0]        flush_p1, flush_nxt;
  logic              redirect_p1, redirect_nxt;
  logic [ADDR_W-1:0] redirect_pc_p1, redirect_pc_nxt;
  logic              br_pend_p1, br_pend_nxt;
  logic [ADDR_W-1:0] br_tgt_p1, br_tgt_nxt;
  logic [ADDR_W-1:0] wake_pc_p1, wake_pc_nxt;
  logic              br_vld;
  logic [ADDR_W-1:0] br_tgt;

  // Stage i must hold whenever it or any later stage requests a stall.
  function automatic logic [5:0] stall_merge(input logic [5:0] req);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 6; i++) begin
      s[i] = |(req >> i);
    end
    return s;
  endfunction

  assign br_vld = branch_i | br_pend_p1;
  assign br_tgt = branch_i ? branch_target_i : br_tgt_p1;

  always_comb begin
    state_nxt       = state_p1;
    cnt_nxt         = cnt_p1;
    flush_nxt       = '0;
    redirect_nxt    = 1'b0;
    redirect_pc_nxt = redirect_pc_p1;
    br_pend_nxt     = br_pend_p1;
    br_tgt_nxt      = br_tgt_p1;
    wake_pc_nxt     = wake_pc_p1;
    case (state_p1)
      RUN: begin
        if (excp_i || ertn_i) begin
          state_nxt       = FLUSH;
          cnt_nxt         = CNT_W'(FLUSH_CYCLES - 1);
          flush_nxt       = FLUSH_ALL;
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = excp_i ? excp_entry_i : ertn_target_i;
          br_pend_nxt     = 1'b0;
        end else if (idle_i) begin
          state_nxt   = IDLE;
          wake_pc_nxt = idle_pc_i + ADDR_W'(4);
          flush_nxt   = FLUSH_FRONT;
          br_pend_nxt = 1'b0;
        end else if (br_vld) begin
          // A stalled back end (or a redirect already in flight) parks the branch.
          if ((|stallreq_i[5:3]) || redirect_p1) begin
            br_pend_nxt = 1'b1;
            br_tgt_nxt  = br_tgt;
          end else begin
            br_pend_nxt     = 1'b0;
            flush_nxt       = FLUSH_FRONT;
            redirect_nxt    = 1'b1;
            redirect_pc_nxt = br_tgt;
          end
        end
      end
      FLUSH: begin
        if (excp_i) begin
          cnt_nxt         = CNT_W'(FLUSH_CYCLES - 1);
          flush_nxt       = FLUSH_ALL;
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = excp_entry_i;
        end else if (cnt_p1 == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt   = cnt_p1 - CNT_W'(1);
          flush_nxt = FLUSH_ALL;
        end
      end
      IDLE: begin
        if (excp_i) begin
          state_nxt       = FLUSH;
          cnt_nxt         = CNT_W'(FLUSH_CYCLES - 1);
          flush_nxt       = FLUSH_ALL;
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = excp_entry_i;
        end else if (int_pending_i) begin
          state_nxt       = WAKE;
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = wake_pc_p1;
        end else begin
          flush_nxt = FLUSH_ID;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Registered control: one cycle from sampled event to flush/redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1       <= RUN;
      cnt_p1         <= '0;
      flush_p1       <= '0;
      redirect_p1    <= 1'b0;
      redirect_pc_p1 <= '0;
      br_pend_p1     <= 1'b0;
    end else begin
      state_p1       <= state_nxt;
      cnt_p1         <= cnt_nxt;
      flush_p1       <= flush_nxt;
      redirect_p1    <= redirect_nxt;
      redirect_pc_p1 <= redirect_pc_nxt;
      br_pend_p1     <= br_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    br_tgt_p1  <= br_tgt_nxt;
    wake_pc_p1 <= wake_pc_nxt;
  end

  always_comb begin
    stall_o = '0;
    case (state_p1)
      RUN:     stall_o = stall_merge(stallreq_i) & ~flush_p1;
      IDLE:    stall_o = 6'b000011;
      default: stall_o = '0;
    endcase
  end

  assign flush_o       = flush_p1;
  assign redirect_o    = redirect_p1;
  assign redirect_pc_o = redirect_pc_p1;
  assign busy_o        = (state_p1 != RUN);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stall merge, exception/ertn flush, branch hold,
// idle/wake and mid-flush reset, each checked against hand-computed values.
module tb_pipeline_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        excp_i;
  logic [31:0] excp_entry_i;
  logic        ertn_i;
  logic [31:0] ertn_target_i;
  logic        idle_i;
  logic [31:0] idle_pc_i;
  logic        int_pending_i;
  logic [5:0]  stall_o;
  logic [5:0]  flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .excp_i(excp_i), .excp_entry_i(excp_entry_i),
    .ertn_i(ertn_i), .ertn_target_i(ertn_target_i), .idle_i(idle_i), .idle_pc_i(idle_pc_i),
    .int_pending_i(int_pending_i), .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stallreq_i = '0; branch_i = 0; branch_target_i = '0; excp_i = 0;
    excp_entry_i = '0; ertn_i = 0; ertn_target_i = '0; idle_i = 0; idle_pc_i = '0; int_pending_i = 0;
    step(); step();
    rst = 1'b0; #1;
    checks++; if (flush_o !== 6'h00) begin errors++; $display("FAIL reset_flush: got %h exp 00", flush_o); end
    checks++; if (stall_o !== 6'h00) begin errors++; $display("FAIL reset_stall: got %h exp 00", stall_o); end
    checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %b/%h exp 0/0", redirect_o, redirect_pc_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
  endtask

  task automatic test_stall_merge();
    stallreq_i = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_o !== 6'b001111) begin errors++; $display("FAIL t1_stall[%0d]: got %b exp 001111", i, stall_o); end
      checks++; if (flush_o !== 6'b000000) begin errors++; $display("FAIL t1_flush[%0d]: got %b exp 000000", i, flush_o); end
      step();
    end
    stallreq_i = 6'b000000; #1;
    checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL t1_release: got %b exp 000000", stall_o); end
    stallreq_i = 6'b100001; #1;
    checks++; if (stall_o !== 6'b111111) begin errors++; $display("FAIL t1_wb_stall: got %b exp 111111", stall_o); end
    stallreq_i = 6'b000001; #1;
    checks++; if (stall_o !== 6'b000001) begin errors++; $display("FAIL t1_pc_stall: got %b exp 000001", stall_o); end
    stallreq_i = '0; #1;
  endtask

  task automatic test_exception();
    excp_i = 1; excp_entry_i = 32'h1C00_8000;
    step();
    excp_i = 0; stallreq_i = 6'b001000; #1;
    checks++; if (flush_o !== 6'h3F) begin errors++; $display("FAIL t2_flush1: got %h exp 3f", flush_o); end
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1C00_8000) begin errors++; $display("FAIL t2_redir1: got %b/%h exp 1/1c008000", redirect_o, redirect_pc_o); end
    checks++; if (busy_o !== 1'b1 || stall_o !== 6'h00) begin errors++; $display("FAIL t2_busy_stall1: got %b/%b exp 1/000000", busy_o, stall_o); end
    step();
    checks++; if (flush_o !== 6'h3F || redirect_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL t2_cycle2: got %h/%b/%b exp 3f/0/1", flush_o, redirect_o, busy_o); end
    stallreq_i = '0;
    step();
    checks++; if (flush_o !== 6'h00 || redirect_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL t2_back_run: got %h/%b/%b exp 00/0/0", flush_o, redirect_o, busy_o); end
  endtask

  task automatic test_ertn();
    ertn_i = 1; ertn_target_i = 32'h1C00_0400; idle_i = 1; branch_i = 1; branch_target_i = 32'h500;
    step();
    ertn_i = 0; idle_i = 0; branch_i = 0;
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1C00_0400 || flush_o !== 6'h3F) begin errors++; $display("FAIL ertn_redir: got %b/%h/%h exp 1/1c000400/3f", redirect_o, redirect_pc_o, flush_o); end
    step(); step();
    checks++; if (busy_o !== 1'b0 || redirect_o !== 1'b0) begin errors++; $display("FAIL ertn_done: got %b/%b exp 0/0", busy_o, redirect_o); end
  endtask

  task automatic test_excp_over_branch();
    branch_i = 1; branch_target_i = 32'h300; excp_i = 1; excp_entry_i = 32'h1C00_9000;
    step();
    branch_i = 0; excp_i = 0;
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1C00_9000) begin errors++; $display("FAIL t3_excp_redir: got %b/%h exp 1/1c009000", redirect_o, redirect_pc_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (redirect_o !== 1'b0 || redirect_pc_o === 32'h300) begin errors++; $display("FAIL t3_no_branch[%0d]: got %b/%h exp 0/not 300", i, redirect_o, redirect_pc_o); end
    end
  endtask

  task automatic test_branch_held();
    branch_i = 1; branch_target_i = 32'h100; stallreq_i = 6'b010000;
    step();
    branch_i = 0; branch_target_i = 32'hDEAD_0000;
    checks++; if (redirect_o !== 1'b0 || stall_o !== 6'b011111) begin errors++; $display("FAIL t4_held1: got %b/%b exp 0/011111", redirect_o, stall_o); end
    step();
    checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL t4_held2: got %b exp 0", redirect_o); end
    stallreq_i = '0;
    step();
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h100 || flush_o !== 6'b000110) begin errors++; $display("FAIL t4_release: got %b/%h/%b exp 1/100/000110", redirect_o, redirect_pc_o, flush_o); end
    step();
    checks++; if (redirect_o !== 1'b0 || flush_o !== 6'b000000) begin errors++; $display("FAIL t4_after: got %b/%b exp 0/000000", redirect_o, flush_o); end
  endtask

  task automatic test_branch_flush_wins();
    branch_i = 1; branch_target_i = 32'h180; stallreq_i = 6'b000100;
    step();
    branch_i = 0;
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h180 || flush_o !== 6'b000110) begin errors++; $display("FAIL br_redir: got %b/%h/%b exp 1/180/000110", redirect_o, redirect_pc_o, flush_o); end
    checks++; if (stall_o !== 6'b000001 || busy_o !== 1'b0) begin errors++; $display("FAIL br_flush_wins: got %b/%b exp 000001/0", stall_o, busy_o); end
    stallreq_i = '0;
    step();
  endtask

  task automatic test_idle_wake();
    idle_i = 1; idle_pc_i = 32'h200;
    step();
    idle_i = 0;
    checks++; if (flush_o !== 6'b000110 || stall_o !== 6'b000011 || busy_o !== 1'b1) begin errors++; $display("FAIL t5_enter: got %b/%b/%b exp 000110/000011/1", flush_o, stall_o, busy_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (flush_o !== 6'b000100 || stall_o !== 6'b000011 || redirect_o !== 1'b0) begin errors++; $display("FAIL t5_idle[%0d]: got %b/%b/%b exp 000100/000011/0", i, flush_o, stall_o, redirect_o); end
    end
    int_pending_i = 1;
    step();
    int_pending_i = 0;
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h204 || flush_o !== 6'h00 || busy_o !== 1'b1) begin errors++; $display("FAIL t5_wake: got %b/%h/%b/%b exp 1/204/000000/1", redirect_o, redirect_pc_o, flush_o, busy_o); end
    step();
    checks++; if (redirect_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL t5_run: got %b/%b exp 0/0", redirect_o, busy_o); end
    idle_i = 1; idle_pc_i = 32'hFFFF_FFFC;
    step();
    idle_i = 0; int_pending_i = 1;
    step();
    int_pending_i = 0;
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_0000) begin errors++; $display("FAIL idle_wrap: got %b/%h exp 1/00000000", redirect_o, redirect_pc_o); end
    step();
  endtask

  task automatic test_excp_in_idle();
    idle_i = 1; idle_pc_i = 32'h400;
    step();
    idle_i = 0; excp_i = 1; int_pending_i = 1; excp_entry_i = 32'h1C00_A000;
    step();
    excp_i = 0; int_pending_i = 0;
    checks++; if (redirect_pc_o !== 32'h1C00_A000 || flush_o !== 6'h3F || stall_o !== 6'h00) begin errors++; $display("FAIL idle_excp: got %h/%h/%b exp 1c00a000/3f/000000", redirect_pc_o, flush_o, stall_o); end
    step(); step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_excp_done: got %b exp 0", busy_o); end
  endtask

  task automatic test_excp_restart();
    excp_i = 1; excp_entry_i = 32'h1C00_8000;
    step();
    excp_entry_i = 32'h1C00_C000;
    step();
    excp_i = 0;
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1C00_C000 || flush_o !== 6'h3F) begin errors++; $display("FAIL restart_redir: got %b/%h/%h exp 1/1c00c000/3f", redirect_o, redirect_pc_o, flush_o); end
    step();
    checks++; if (flush_o !== 6'h3F || redirect_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL restart_hold: got %h/%b/%b exp 3f/0/1", flush_o, redirect_o, busy_o); end
    step();
    checks++; if (flush_o !== 6'h00 || busy_o !== 1'b0) begin errors++; $display("FAIL restart_done: got %h/%b exp 00/0", flush_o, busy_o); end
  endtask

  task automatic test_reset_mid_flush();
    excp_i = 1; excp_entry_i = 32'h1C00_8000;
    step();
    excp_i = 0; rst = 1;
    step();
    checks++; if (flush_o !== 6'h00 || stall_o !== 6'h00 || redirect_o !== 1'b0 || redirect_pc_o !== 32'h0 || busy_o !== 1'b0) begin errors++; $display("FAIL t6_reset: got %h/%h/%b/%h/%b exp 00/00/0/0/0", flush_o, stall_o, redirect_o, redirect_pc_o, busy_o); end
    rst = 0;
    step();
    checks++; if (flush_o !== 6'h00 || busy_o !== 1'b0) begin errors++; $display("FAIL t6_stays_run: got %h/%b exp 00/0", flush_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_stall_merge();
    test_exception();
    test_ertn();
    test_excp_over_branch();
    test_branch_held();
    test_branch_flush_wins();
    test_idle_wake();
    test_excp_in_idle();
    test_excp_restart();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
